// File: rtl/dct_block_sequencer_if.sv
// Strobe/handshake bundle between dct_block_sequencer and the block buffer, 1-D DCT core and stream ports.
interface dct_block_sequencer_if;
    localparam int unsigned ELEM_W = 6;
    localparam int unsigned LINE_W = 3;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] buf_addr;
    logic              buf_we;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [LINE_W-1:0] vec_idx;
    logic              vec_dir;
    logic              core_start;
    logic              core_done;
    logic              vec_wb;

    modport master (
        input  in_valid, out_ready, core_done,
        output in_ready, buf_addr, buf_we, out_valid, out_last,
               vec_idx, vec_dir, core_start, vec_wb
    );

    modport slave (
        output in_valid, out_ready, core_done,
        input  in_ready, buf_addr, buf_we, out_valid, out_last,
               vec_idx, vec_dir, core_start, vec_wb
    );
endinterface

// File: rtl/dct_block_sequencer.sv
// Control FSM for one 8x8 2-D DCT: load 64 samples, 8 row + 8 column core passes, drain 64 coefficients.
// Optional core watchdog with sticky err/ERR state: define DCT_CORE_WDT_EN.
module dct_block_sequencer #(
    parameter int unsigned WDT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    dct_block_sequencer_if.master dct,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned       ELEM_W    = 6;
    localparam int unsigned       LINE_W    = 3;
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(63);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(7);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ROW_ISSUE = 3'd2,
        S_ROW_WAIT  = 3'd3,
        S_COL_ISSUE = 3'd4,
        S_COL_WAIT  = 3'd5,
        S_DRAIN     = 3'd6
`ifdef DCT_CORE_WDT_EN
        , S_ERR     = 3'd7
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [ELEM_W-1:0] elem_cnt, elem_nxt;
    logic [LINE_W-1:0] line, line_nxt;
    logic              done_q, done_nxt;

`ifdef DCT_CORE_WDT_EN
    localparam int unsigned      WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt, wdt_nxt;
    logic             err_q, err_nxt;
`endif

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            elem_cnt <= '0;
            line     <= '0;
            done_q   <= 1'b0;
`ifdef DCT_CORE_WDT_EN
            wdt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            elem_cnt <= elem_nxt;
            line     <= line_nxt;
            done_q   <= done_nxt;
`ifdef DCT_CORE_WDT_EN
            wdt      <= wdt_nxt;
            err_q    <= err_nxt;
`endif
        end
    end

    // Next-state and counter update; counters hold at their terminal value
    always_comb begin
        state_nxt = state;
        elem_nxt  = elem_cnt;
        line_nxt  = line;
        done_nxt  = 1'b0;
`ifdef DCT_CORE_WDT_EN
        wdt_nxt   = wdt;
        err_nxt   = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    elem_nxt  = '0;
                end
            end
            S_LOAD: begin
                if (dct.in_valid) begin
                    if (elem_cnt == ELEM_LAST) begin
                        state_nxt = S_ROW_ISSUE;
                        line_nxt  = '0;
                    end else begin
                        elem_nxt = elem_cnt + ELEM_W'(1);
                    end
                end
            end
            S_ROW_ISSUE: begin
                state_nxt = S_ROW_WAIT;
`ifdef DCT_CORE_WDT_EN
                wdt_nxt   = '0;
`endif
            end
            S_COL_ISSUE: begin
                state_nxt = S_COL_WAIT;
`ifdef DCT_CORE_WDT_EN
                wdt_nxt   = '0;
`endif
            end
            S_ROW_WAIT, S_COL_WAIT: begin
                if (dct.core_done) begin
                    if (line == LINE_LAST) begin
                        if (state == S_ROW_WAIT) begin
                            state_nxt = S_COL_ISSUE;
                            line_nxt  = '0;
                        end else begin
                            state_nxt = S_DRAIN;
                            elem_nxt  = '0;
                        end
                    end else begin
                        line_nxt  = line + LINE_W'(1);
                        state_nxt = (state == S_ROW_WAIT) ? S_ROW_ISSUE : S_COL_ISSUE;
                    end
                end
`ifdef DCT_CORE_WDT_EN
                else if (wdt == WDT_LAST) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end else begin
                    wdt_nxt = wdt + WDT_W'(1);
                end
`endif
            end
            S_DRAIN: begin
                if (dct.out_ready) begin
                    if (elem_cnt == ELEM_LAST) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        elem_nxt = elem_cnt + ELEM_W'(1);
                    end
                end
            end
`ifdef DCT_CORE_WDT_EN
            S_ERR: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    elem_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes decoded from state and same-cycle handshake inputs
    always_comb begin
        dct.in_ready   = 1'b0;
        dct.buf_we     = 1'b0;
        dct.out_valid  = 1'b0;
        dct.out_last   = 1'b0;
        dct.core_start = 1'b0;
        dct.vec_dir    = 1'b0;
        dct.vec_wb     = 1'b0;
        busy           = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                dct.in_ready = 1'b1;
                dct.buf_we   = dct.in_valid;
            end
            S_ROW_ISSUE: dct.core_start = 1'b1;
            S_ROW_WAIT:  dct.vec_wb     = dct.core_done;
            S_COL_ISSUE: begin
                dct.core_start = 1'b1;
                dct.vec_dir    = 1'b1;
            end
            S_COL_WAIT: begin
                dct.vec_wb  = dct.core_done;
                dct.vec_dir = 1'b1;
            end
            S_DRAIN: begin
                dct.out_valid = 1'b1;
                dct.out_last  = (elem_cnt == ELEM_LAST);
            end
            default: ;
        endcase
    end

    assign dct.buf_addr = elem_cnt;
    assign dct.vec_idx  = line;
    assign done         = done_q;
`ifdef DCT_CORE_WDT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer: expected write/writeback/drain events queued per block, checked as they appear.
module tb_dct_block_sequencer;
    localparam int unsigned WDT = 64;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, err;

    dct_block_sequencer_if dct ();

    dct_block_sequencer #(.WDT_CYCLES(WDT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dct   (dct),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected events: write addr; {dir,idx}; {last,addr}
    int exp_wr[$];
    int exp_wb[$];
    int exp_out[$];

    // per-block stimulus configuration
    int cfg_lat     = 1;
    bit cfg_toggle  = 0;
    int cfg_or_lo   = 0;
    int cfg_or_n    = 0;
    bit cfg_spur    = 0;
    bit cfg_pre     = 0;
    bit cfg_chain   = 0;
    int cfg_stop    = 0;
    bit cfg_rst     = 0;
    bit cfg_hang_en = 0;
    int cfg_hang    = 0;
    bit stray_hi    = 0;
    int starts_seen = 0;

    // core model: answers core_start after cfg_lat cycles unless told to hang
    initial begin
        int cnt;
        cnt = 0;
        dct.core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dct.core_start === 1'b1) begin
                if (!(cfg_hang_en && starts_seen == cfg_hang)) cnt = cfg_lat;
                starts_seen++;
            end
            @(posedge clk);
            #1;
            if (cnt == 1) begin
                dct.core_done = 1'b1;
                cnt = 0;
            end else begin
                dct.core_done = stray_hi;
                if (cnt > 1) cnt--;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin : mon
        int e;
        int o;
        if (dct.buf_we === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: buf_we at addr %0d, none expected", dct.buf_addr);
            end else begin
                e = exp_wr.pop_front();
                o = int'({dct.in_ready, dct.buf_addr});
                if (o !== 64 + e) begin
                    errors++;
                    $display("FAIL wr_addr: got {in_ready,addr}=%0d want %0d", o, 64 + e);
                end
            end
        end
        if (dct.vec_wb === 1'b1) begin
            checks++;
            if (exp_wb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: vec_wb dir %0d idx %0d, none expected", dct.vec_dir, dct.vec_idx);
            end else begin
                e = exp_wb.pop_front();
                o = int'({dct.vec_dir, dct.vec_idx});
                if (o !== e) begin
                    errors++;
                    $display("FAIL wb_line: got {dir,idx}=%0d want %0d", o, e);
                end
            end
        end
        if (dct.out_valid === 1'b1 && dct.out_ready === 1'b1) begin
            checks++;
            if (exp_out.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: output addr %0d, none expected", dct.buf_addr);
            end else begin
                e = exp_out.pop_front();
                o = int'({dct.out_last, dct.buf_addr});
                if (o !== e) begin
                    errors++;
                    $display("FAIL out_addr: got {last,addr}=%0d want %0d", o, e);
                end
            end
        end
    end

    // one block from start to done; cycle 0 is the start cycle, done cycle expected at 161 + stalls
    task automatic run_block(output int done_cyc);
        int exp_done;
        int held;
        bit stall_prev;
        for (int i = 0; i < 64; i++) exp_wr.push_back(i);
        for (int i = 0; i < 16; i++) exp_wb.push_back(i);
        for (int i = 0; i < 64; i++) exp_out.push_back((i == 63) ? 64 + i : i);
        starts_seen = 0;
        exp_done = 161 + (cfg_toggle ? 63 : 0) + 16 * (cfg_lat - 1) + cfg_or_n;
        if (!cfg_pre) begin
            @(posedge clk);
            #1;
            start = 1'b1;
        end
        done_cyc = 0;
        stall_prev = 0;
        held = 0;
        for (int c = 1; c <= exp_done + 20 && done_cyc == 0; c++) begin
            @(posedge clk);
            #1;
            start         = (cfg_spur && c >= 66 && c <= 90) || (cfg_chain && c == exp_done);
            dct.in_valid  = cfg_toggle ? c[0] : 1'b1;
            dct.out_ready = !(cfg_or_n > 0 && c >= cfg_or_lo && c < cfg_or_lo + cfg_or_n);
            if (cfg_rst && c == cfg_stop) reset = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({dct.in_ready, busy, err} !== 3'b110) begin
                    errors++;
                    $display("FAIL load_entry: {in_ready,busy,err}=%b want 110", {dct.in_ready, busy, err});
                end
            end
            if (dct.out_valid === 1'b1 && dct.out_ready === 1'b0) begin
                if (stall_prev) begin
                    checks++;
                    if (int'(dct.buf_addr) !== held) begin
                        errors++;
                        $display("FAIL drain_hold: buf_addr %0d want %0d", dct.buf_addr, held);
                    end
                end
                held = int'(dct.buf_addr);
                stall_prev = 1;
            end else begin
                stall_prev = 0;
            end
            if (cfg_stop != 0 && c == cfg_stop) break;
            if (done === 1'b1) done_cyc = c;
        end
        if (cfg_stop != 0) return;
        checks++;
        if (done_cyc !== exp_done) begin
            errors++;
            $display("FAIL latency: done at cycle %0d want %0d", done_cyc, exp_done);
        end
        checks++;
        if (exp_wr.size() + exp_wb.size() + exp_out.size() !== 0) begin
            errors++;
            $display("FAIL missing_events: wr %0d wb %0d out %0d left", exp_wr.size(), exp_wb.size(), exp_out.size());
        end
        exp_wr.delete();
        exp_wb.delete();
        exp_out.delete();
        if (!cfg_chain) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL done_pulse: {done,busy}=%b want 00", {done, busy});
            end
        end
    endtask

    task automatic cfg_default();
        cfg_lat = 1; cfg_toggle = 0; cfg_or_lo = 0; cfg_or_n = 0; cfg_spur = 0;
        cfg_pre = 0; cfg_chain = 0; cfg_stop = 0; cfg_rst = 0; cfg_hang_en = 0; stray_hi = 0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({dct.in_ready, dct.buf_we, dct.out_valid, dct.out_last, dct.core_start,
             dct.vec_wb, busy, done, err} !== 9'b0) begin
            errors++;
            $display("FAIL %s_strobes: got %b want 0", name, {dct.in_ready, dct.buf_we, dct.out_valid,
                     dct.out_last, dct.core_start, dct.vec_wb, busy, done, err});
        end
        checks++;
        if ({dct.buf_addr, dct.vec_idx, dct.vec_dir} !== 10'b0) begin
            errors++;
            $display("FAIL %s_addrs: buf_addr %0d vec_idx %0d vec_dir %0d want 0", name,
                     dct.buf_addr, dct.vec_idx, dct.vec_dir);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        dct.in_valid  = 1'b1;
        dct.out_ready = 1'b1;
        stray_hi = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dct.in_ready, busy} !== 2'b00) begin
                errors++;
                $display("FAIL idle_no_start: {in_ready,busy}=%b want 00", {dct.in_ready, busy});
            end
        end
        stray_hi = 0;
    endtask

    task automatic test_basic();
        int d;
        cfg_default();
        run_block(d);
    endtask

    task automatic test_stalls();
        int d;
        cfg_default();
        cfg_toggle = 1;
        cfg_or_lo  = 170;
        cfg_or_n   = 5;
        run_block(d);
    endtask

    task automatic test_stray_inputs();
        int d;
        cfg_default();
        stray_hi = 1;
        cfg_spur = 1;
        run_block(d);
        stray_hi = 0;
    endtask

    task automatic test_slow_core();
        int d;
        cfg_default();
        cfg_lat = 3;
        run_block(d);
    endtask

    task automatic test_back_to_back();
        int d;
        cfg_default();
        cfg_chain = 1;
        run_block(d);
        cfg_chain = 0;
        cfg_pre   = 1;
        run_block(d);
    endtask

    // col line 4 WAIT with 2-cycle core is cycle 102
    task automatic test_abort();
        int d;
        cfg_default();
        cfg_lat  = 2;
        cfg_stop = 102;
        cfg_rst  = 1;
        run_block(d);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("abort");
        checks++;
        if ({exp_wr.size(), exp_wb.size(), exp_out.size()} !== {32'd0, 32'd4, 32'd64}) begin
            errors++;
            $display("FAIL abort_events: wr %0d wb %0d out %0d left, want 0 4 64",
                     exp_wr.size(), exp_wb.size(), exp_out.size());
        end
        exp_wr.delete();
        exp_wb.delete();
        exp_out.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cfg_default();
        run_block(d);
    endtask

`ifdef DCT_CORE_WDT_EN
    // row 2 WAIT spans cycles 70..133; ERR from cycle 134
    task automatic test_wdt();
        int d;
        cfg_default();
        cfg_hang_en = 1;
        cfg_hang    = 2;
        cfg_stop    = 133;
        run_block(d);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL wdt_early: {err,busy}=%b want 01", {err, busy});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if ({err, busy, dct.in_ready, dct.buf_we, dct.out_valid, dct.core_start, dct.vec_wb} !== 7'b1100000) begin
                errors++;
                $display("FAIL wdt_err: {err,busy,strobes}=%b want 1100000",
                         {err, busy, dct.in_ready, dct.buf_we, dct.out_valid, dct.core_start, dct.vec_wb});
            end
        end
        checks++;
        if ({exp_wr.size(), exp_wb.size(), exp_out.size()} !== {32'd0, 32'd14, 32'd64}) begin
            errors++;
            $display("FAIL wdt_events: wr %0d wb %0d out %0d left, want 0 14 64",
                     exp_wr.size(), exp_wb.size(), exp_out.size());
        end
        exp_wr.delete();
        exp_wb.delete();
        exp_out.delete();
        cfg_default();
        run_block(d);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_stray_inputs();
        test_slow_core();
        test_back_to_back();
        test_abort();
`ifdef DCT_CORE_WDT_EN
        test_wdt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
